// File: rtl/bridge_decoder.sv
// Address decoder for a simple host bus fanning out to N_SLAVES bridge slaves, with read timeout.
// Define BRIDGE_DECODER_ERR_COUNT_EN to build the saturating decode/timeout error counter.
module bridge_decoder #(
  parameter int                      N_SLAVES       = 4,
  // Slot 0 occupies the least significant 32 bits, so it is the rightmost literal.
  parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE     = {32'h0000_0000, 32'h2000_0000,
                                                       32'h1000_0000, 32'hF800_0000},
  parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK     = {32'hF000_0000, 32'hF000_0000,
                                                       32'hF000_0000, 32'hFFFF_FF00},
  parameter int                      TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic                     wr,
  input  logic [31:0]              wr_data,
  input  logic                     rd,
  output logic [31:0]              rd_data,
  output logic                     rd_data_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wr_data,
  output logic [N_SLAVES-1:0]      s_wr,
  output logic [N_SLAVES-1:0]      s_rd,
  input  logic [N_SLAVES*32-1:0]   s_rd_data,
  input  logic [N_SLAVES-1:0]      s_rd_data_valid,
  output logic [15:0]              err_count
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = 8;

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t               state_reg, state_next;
  logic [N_SLAVES-1:0]  hit, first_hit;
  logic                 any_hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [31:0]          slot_data [N_SLAVES];

  logic [IDX_W-1:0]     sel_reg, sel_next;
  logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [N_SLAVES-1:0]  s_wr_reg, s_wr_next, s_rd_reg, s_rd_next;
  logic [31:0]          s_addr_reg, s_wr_data_reg, rd_data_reg, rd_data_next;
  logic                 rd_valid_reg, rd_valid_next;
  logic                 sel_valid, timeout;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slot
      assign hit[gi] = (addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32];
      assign slot_data[gi] = s_rd_data[gi*32 +: 32];
    end
  endgenerate

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign first_hit = hit & (~hit + N_SLAVES'(1));
  assign any_hit   = |hit;

  always_comb begin
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  assign sel_valid = s_rd_data_valid[sel_reg];
  assign timeout   = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rd && any_hit) state_next = WAIT_RD;
      WAIT_RD: if (sel_valid || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_wr_next     = (wr && any_hit) ? first_hit : '0;
    s_rd_next     = '0;
    rd_valid_next = 1'b0;
    rd_data_next  = rd_data_reg;
    sel_next      = sel_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (rd) begin
          if (any_hit) begin
            s_rd_next     = first_hit;
            sel_next      = hit_idx;
            wait_cnt_next = '0;
          end else begin
            rd_valid_next = 1'b1;
            rd_data_next  = 32'hFFFF_FFFF;
          end
        end
      end
      WAIT_RD: begin
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        // A slave answer in the timeout cycle still wins over the timeout.
        if (sel_valid) begin
          rd_valid_next = 1'b1;
          rd_data_next  = slot_data[sel_reg];
        end else if (timeout) begin
          rd_valid_next = 1'b1;
          rd_data_next  = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_wr_reg      <= '0;
      s_rd_reg      <= '0;
      s_addr_reg    <= '0;
      s_wr_data_reg <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      sel_reg       <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      s_wr_reg     <= s_wr_next;
      s_rd_reg     <= s_rd_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      sel_reg      <= sel_next;
      wait_cnt_reg <= wait_cnt_next;
      if (wr || rd) begin
        s_addr_reg    <= addr;
        s_wr_data_reg <= wr_data;
      end
    end
  end

`ifdef BRIDGE_DECODER_ERR_COUNT_EN
  logic [15:0] err_count_reg;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // A dropped host read and a timeout can land in the same cycle: two events.
  always_comb begin
    err_inc = {1'b0, rd && (state_reg == IDLE) && !any_hit}
            + {1'b0, rd && (state_reg == WAIT_RD)}
            + {1'b0, (state_reg == WAIT_RD) && !sel_valid && timeout};
    err_sum = {1'b0, err_count_reg} + {15'd0, err_inc};
  end

  always_ff @(posedge clk) begin
    if (reset)           err_count_reg <= '0;
    else if (err_sum[16]) err_count_reg <= 16'hFFFF;
    else                 err_count_reg <= err_sum[15:0];
  end

  assign err_count = err_count_reg;
`else
  assign err_count = 16'd0;
`endif

  assign s_wr          = s_wr_reg;
  assign s_rd          = s_rd_reg;
  assign s_addr        = s_addr_reg;
  assign s_wr_data     = s_wr_data_reg;
  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_valid_reg;

endmodule
